// File: rtl/ether_pkg.sv
// ether_pkg: shared bus field indices, minimum frame length and arbiter states for the reply path
package ether_pkg;
  localparam int BUS_OK     = 10;
  localparam int BUS_STROBE = 9;
  localparam int BUS_WRITE  = 8;
  localparam int MIN_FRAME  = 60;
  typedef enum logic [1:0] {IDLE, GRANT, SEND} arb_state_e;
endpackage

// File: rtl/reply_arb_if.sv
// reply_arb_if: reply buses in, transmit byte stream out
//   rx_bus  NPORT x {ok, strobe, write, data[7:0]}
//   tx_*    valid/ready byte stream with sop/eop and source port
//   pending committed-unsent flags, drop one-cycle discard pulses
interface reply_arb_if #(parameter int NPORT = 3);
  logic [NPORT*11-1:0] rx_bus;
  logic                tx_ready;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_sop;
  logic                tx_eop;
  logic [1:0]          tx_port;
  logic [NPORT-1:0]    pending;
  logic [NPORT-1:0]    drop;
  modport slave  (input rx_bus, tx_ready, output tx_data, tx_valid, tx_sop, tx_eop, tx_port, pending, drop);
  modport master (output rx_bus, tx_ready, input tx_data, tx_valid, tx_sop, tx_eop, tx_port, pending, drop);
endinterface

// File: rtl/reply_buf.sv
// reply_buf: per-port reply buffer with commit/drop logic and registered synchronous read
//   bus_i   {ok, strobe, write, data}   re_i/raddr_i  read enable/address (data in rdata_o next cycle)
//   clr_i   release the pending reply   len_o/pend_o  committed length and pending flag
//   drop_o  registered discard pulse
module reply_buf
  import ether_pkg::*;
#(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [10:0]   bus_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  input  logic          clr_i,
  output logic [7:0]    rdata_o,
  output logic [AW:0]   len_o,
  output logic          pend_o,
  output logic          drop_o
);
  logic [7:0]  mem_q [2**AW];
  logic [7:0]  rdata_q;
  logic [AW:0] wp_q, wp_d, len_q;
  logic        pend_q, ovf_q, ovf_d, lost_q, drop_q;
  logic        wr, st, store, commit;
  always_comb begin
    wr     = bus_i[BUS_WRITE];
    st     = bus_i[BUS_STROBE];
    store  = wr & !pend_q & !wp_q[AW];
    wp_d   = wp_q + {{AW{1'b0}}, store};
    ovf_d  = ovf_q | (wr & !pend_q & wp_q[AW]);
    // a byte written in the strobe cycle is part of the committed reply
    commit = st & !pend_q & !lost_q & bus_i[BUS_OK] & !ovf_d & (wp_d != '0);
  end
  always_ff @(posedge clk)
    if (store) mem_q[wp_q[AW-1:0]] <= bus_i[7:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      len_q   <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      lost_q  <= 1'b0;
      drop_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      wp_q   <= st ? '0 : wp_d;
      ovf_q  <= !st & ovf_d;
      lost_q <= !st & (lost_q | (wr & pend_q));
      pend_q <= !clr_i & (pend_q | commit);
      drop_q <= st & !commit;
      if (commit) len_q <= wp_d;
      if (re_i) rdata_q <= mem_q[raddr_i];
    end
  end
  assign rdata_o = rdata_q;
  assign len_o   = len_q;
  assign pend_o  = pend_q;
  assign drop_o  = drop_q;
endmodule

// File: rtl/reply_arb.sv
// reply_arb: buffers one reply per port and streams committed replies round-robin to the MAC
//   clk, rst_n (async, active-low); bus_io: reply_arb_if.slave (rx_bus in, tx stream/pending/drop out)
//   REPLY_ARB_PAD_EN: pad frames shorter than MIN_FRAME with 0x00 bytes
module reply_arb
  import ether_pkg::*;
#(
  parameter int NPORT = 3,
  parameter int AW    = 7
) (
  input logic        clk,
  input logic        rst_n,
  reply_arb_if.slave bus_io
);
  localparam int CW = (AW + 1 > 7) ? AW + 1 : 7;
  arb_state_e       st_q;
  logic [1:0]       port_q, last_q, gnt;
  logic [CW-1:0]    idx_q, tot;
  logic             valid_q, sop_q, eop_q;
  logic [NPORT-1:0] pend, drop, re, clr;
  logic [7:0]       rdata [NPORT];
  logic [AW:0]      len [NPORT];
  logic [AW:0]      len_sel;
  logic [7:0]       dat;
  logic [AW-1:0]    raddr;
  int               best, d;
  for (genvar i = 0; i < NPORT; i++) begin : g_buf
    reply_buf #(.AW(AW)) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus_i   (bus_io.rx_bus[11*i +: 11]),
      .re_i    (re[i]),
      .raddr_i (raddr),
      .clr_i   (clr[i]),
      .rdata_o (rdata[i]),
      .len_o   (len[i]),
      .pend_o  (pend[i]),
      .drop_o  (drop[i])
    );
  end
  // round-robin: smallest distance from last grant + 1 wins
  always_comb begin
    gnt  = '0;
    best = NPORT;
    d    = 0;
    for (int p = 0; p < NPORT; p++) begin
      d = (p + NPORT - 1 - int'(last_q)) % NPORT;
      if (pend[p] && d < best) begin
        best = d;
        gnt  = 2'(p);
      end
    end
  end
  always_comb begin
    len_sel = '0;
    dat     = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (2'(p) == ((st_q == GRANT) ? gnt : port_q)) len_sel = len[p];
      if (2'(p) == port_q) dat = rdata[p];
    end
    raddr = (st_q == GRANT) ? '0 : AW'(idx_q + 1'b1);
    for (int p = 0; p < NPORT; p++) begin
      re[p]  = (st_q == GRANT && gnt == 2'(p)) || (st_q == SEND && bus_io.tx_ready && !eop_q && port_q == 2'(p));
      clr[p] = st_q == SEND && bus_io.tx_ready && eop_q && port_q == 2'(p);
    end
  end
`ifdef REPLY_ARB_PAD_EN
  assign tot            = (CW'(len_sel) < CW'(MIN_FRAME)) ? CW'(MIN_FRAME) : CW'(len_sel);
  // bytes past the stored length are pad, whatever the memory returned
  assign bus_io.tx_data = (idx_q < CW'(len_sel)) ? dat : 8'h00;
`else
  assign tot            = CW'(len_sel);
  assign bus_io.tx_data = dat;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      port_q  <= '0;
      last_q  <= 2'(NPORT - 1);
      idx_q   <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      case (st_q)
        IDLE: if (|pend) st_q <= GRANT;
        GRANT: begin
          port_q  <= gnt;
          last_q  <= gnt;
          idx_q   <= '0;
          valid_q <= 1'b1;
          sop_q   <= 1'b1;
          eop_q   <= tot == CW'(1);
          st_q    <= SEND;
        end
        SEND: begin
          if (bus_io.tx_ready && eop_q) begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            st_q    <= IDLE;
          end else if (bus_io.tx_ready) begin
            idx_q <= idx_q + 1'b1;
            sop_q <= 1'b0;
            eop_q <= idx_q + CW'(2) == tot;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end
  assign bus_io.tx_valid = valid_q;
  assign bus_io.tx_sop   = sop_q;
  assign bus_io.tx_eop   = eop_q;
  assign bus_io.tx_port  = port_q;
  assign bus_io.pending  = pend;
  assign bus_io.drop     = drop;
endmodule

// File: tb/tb_reply_arb.sv
// tb_reply_arb: random reply traffic checked against a transaction-level model of buffers and scheduler
module tb_reply_arb;
  import ether_pkg::*;
  localparam int NP = 3, AW = 7, DEPTH = 1 << AW;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  reply_arb_if #(.NPORT(NP)) bus ();
  reply_arb #(.NPORT(NP), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus_io(bus));
  int total = 0, bad = 0;
  logic [7:0] wb [NP][DEPTH];
  logic [7:0] fb [NP][DEPTH];
  int wn [NP], fl [NP];
  bit m_ovf [NP], m_lost [NP], m_pend [NP], m_drop [NP];
  int ph, sp, sidx, stot, last;
  int gl [NP], gi [NP];
  bit gok [NP], gm [NP];
  logic [7:0] gb [NP];
  bit rnd;
  logic [NP*11-1:0] bv;
  bit rdy;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask
  function automatic int tot_of(input int n);
`ifdef REPLY_ARB_PAD_EN
    return n < MIN_FRAME ? MIN_FRAME : n;
`else
    return n;
`endif
  endfunction
  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      wn[p] = 0; fl[p] = 0;
      m_ovf[p] = 0; m_lost[p] = 0; m_pend[p] = 0; m_drop[p] = 0;
    end
    ph = 0; sp = 0; sidx = 0; stot = 0; last = NP - 1;
  endtask
  task automatic new_pkt(input int p);
    if (!rnd) begin
      gi[p] = 1 << 30; gl[p] = 0;
    end else begin
      gl[p] = $urandom_range(24, 0) == 0 ? 0 : $urandom_range(15, 0) == 0 ? DEPTH - 2 + $urandom_range(4, 0) : $urandom_range(70, 1);
      gb[p] = 8'($urandom);
      gok[p] = $urandom_range(5, 0) != 0;
      gm[p] = $urandom_range(1, 0) == 1;
      gi[p] = $urandom_range(119, 0);
    end
  endtask
  task automatic gen_cycle(output logic [NP*11-1:0] v);
    logic [10:0] b;
    v = '0;
    for (int p = 0; p < NP; p++) begin
      b = '0;
      if (gi[p] > 0) gi[p]--;
      else if (gl[p] > 0) begin
        if (!rnd || $urandom_range(7, 0) != 0) begin
          b[8] = 1; b[7:0] = gb[p]; gb[p]++; gl[p]--;
          if (gl[p] == 0 && gm[p]) begin
            b[9] = 1; b[10] = gok[p]; new_pkt(p);
          end
        end
      end else begin
        b[9] = 1; b[10] = gok[p]; new_pkt(p);
      end
      v[11*p +: 11] = b;
    end
  endtask
  task automatic check_outputs();
    logic [NP-1:0] pv, dv;
    for (int p = 0; p < NP; p++) begin
      pv[p] = m_pend[p]; dv[p] = m_drop[p];
    end
    check("pending", 32'(bus.pending), 32'(pv));
    check("drop", 32'(bus.drop), 32'(dv));
    check("tx_valid", 32'(bus.tx_valid), 32'(ph == 2));
    if (ph == 2) begin
      check("tx_port", 32'(bus.tx_port), 32'(sp));
      check("tx_sop", 32'(bus.tx_sop), 32'(sidx == 0));
      check("tx_eop", 32'(bus.tx_eop), 32'(sidx == stot - 1));
      check("tx_data", 32'(bus.tx_data), 32'(sidx < fl[sp] ? fb[sp][sidx] : 8'h00));
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_valid"}, 32'(bus.tx_valid), 0);
    check({tag, "_sop"}, 32'(bus.tx_sop), 0);
    check({tag, "_eop"}, 32'(bus.tx_eop), 0);
    check({tag, "_port"}, 32'(bus.tx_port), 0);
    check({tag, "_data"}, 32'(bus.tx_data), 0);
    check({tag, "_pending"}, 32'(bus.pending), 0);
    check({tag, "_drop"}, 32'(bus.drop), 0);
  endtask
  // advance the model across one rising edge with the inputs applied this cycle
  task automatic model_step(input logic [NP*11-1:0] v, input bit r);
    int clr = -1;
    bit anyp = 0;
    int best = NP;
    logic [10:0] b;
    bit pp, lp;
    for (int p = 0; p < NP; p++) anyp |= m_pend[p];
    if (ph == 0) begin
      if (anyp) ph = 1;
    end else if (ph == 1) begin
      for (int p = 0; p < NP; p++)
        if (m_pend[p] && (p - last - 1 + 2 * NP) % NP < best) begin
          best = (p - last - 1 + 2 * NP) % NP; sp = p;
        end
      last = sp; sidx = 0; stot = tot_of(fl[sp]); ph = 2;
    end else if (r) begin
      if (sidx == stot - 1) begin
        clr = sp; ph = 0;
      end else sidx++;
    end
    for (int p = 0; p < NP; p++) begin
      b = v[11*p +: 11];
      pp = m_pend[p]; lp = m_lost[p];
      m_drop[p] = 0;
      if (b[8]) begin
        if (pp) m_lost[p] = 1;
        else if (wn[p] < DEPTH) begin
          wb[p][wn[p]] = b[7:0]; wn[p]++;
        end else m_ovf[p] = 1;
      end
      if (b[9]) begin
        if (pp || lp) m_drop[p] = 1;
        else if (b[10] && !m_ovf[p] && wn[p] > 0) begin
          for (int i = 0; i < wn[p]; i++) fb[p][i] = wb[p][i];
          fl[p] = wn[p]; m_pend[p] = 1;
        end else m_drop[p] = 1;
        wn[p] = 0; m_ovf[p] = 0; m_lost[p] = 0;
      end
      if (clr == p) m_pend[p] = 0;
    end
  endtask
  initial begin
    bus.rx_bus = '0;
    bus.tx_ready = 0;
    rnd = 0;
    model_reset();
    for (int p = 0; p < NP; p++) new_pkt(p);
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1;
    gl[1] = 42; gb[1] = 8'h00; gok[1] = 1; gm[1] = 0; gi[1] = 0;
    for (int c = 0; c < 8000; c++) begin
      if (c == 4000) begin
        #2 rst_n = 0;
        #1 check_reset("midreset");
        model_reset();
        bus.rx_bus = '0;
        @(negedge clk);
        rst_n = 1;
        for (int p = 0; p < NP; p++) new_pkt(p);
      end
      check_outputs();
      if (c == 120)
        for (int p = 0; p < NP; p++) begin
          gl[p] = 12; gi[p] = 0; gm[p] = 0; gok[p] = 1; gb[p] = 8'(p * 16);
        end
      if (c == 170) begin
        gl[0] = 5; gi[0] = 0; gok[0] = 1; gm[0] = 1; gb[0] = 8'hA0;
      end
      if (c == 260) begin
        rnd = 1;
        for (int p = 0; p < NP; p++) new_pkt(p);
      end
      case ((c / 500) % 3)
        0: rdy = 1;
        1: rdy = (c % 4 == 0) || (c % 4 == 3);
        default: rdy = $urandom_range(1, 0) == 1;
      endcase
      bus.tx_ready = rdy;
      gen_cycle(bv);
      bus.rx_bus = bv;
      model_step(bv, rdy);
      @(negedge clk);
    end
    check_outputs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reply_arb.md
# reply_arb

Transmit-side scheduler for the Ethernet reply path. Accepts up to four 11-bit reply buses `{ok, strobe, write, data[7:0]}` from the protocol receivers (ICMP echo, ARP, UDP), buffers one candidate reply per port, and commits it on a good CRC. Committed replies are streamed one at a time, round-robin, to the MAC transmitter over a valid/ready byte stream.

## Interface
- `NPORT`, 3: number of reply buses. Legal range 2..4.
- `AW`, 7: buffer address width. Each port holds 2^AW bytes.
- `clk` input 1: single clock. All logic is on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `rx_bus` input NPORT*11: port p occupies bits [11p+10:11p]. Bit 10 is ok, 9 is strobe, 8 is write, 7:0 is data.
- `tx_ready` input 1: transmitter accepts the current byte.
- `tx_data` output 8: reply byte.
- `tx_valid` output 1: `tx_data` is valid.
- `tx_sop` output 1: first byte of a frame, qualified by `tx_valid`.
- `tx_eop` output 1: last byte of a frame, qualified by `tx_valid`.
- `tx_port` output 2: index of the port being sent. Stable for the whole frame.
- `pending` output NPORT: the port has a committed, unsent reply.
- `drop` output NPORT: one-cycle pulse when a port's reply is discarded.

## Operation
- Each port has a per-port buffer with a write pointer `wp` (width AW+1), a length register, and flags `pend` and `ovf`.
- **Write.** When write=1, `pend`=0 and `wp`<2^AW:
  - store data at `wp`;
  - increment `wp`.
- **Overflow.** When write=1 and `wp`=2^AW, set `ovf`. The byte is not stored.
- **Write while pending.** When write=1 and `pend`=1, ignore the byte and set a sticky `lost` flag.
- **Strobe.** On strobe=1, exactly one of the following applies:
  - `pend`=1: pulse `drop` (because of `lost`). The pending reply is untouched.
  - Otherwise, if ok=1, `ovf`=0 and `wp`>0: latch length=`wp` and set `pend`=1.
  - Otherwise (ok=0, `ovf`=1 or `wp`=0): pulse `drop`.
  - In every case, clear `wp`, `ovf` and `lost`.
- **Write and strobe in the same cycle.** The byte is stored first, and the committed length includes it.
- **Arbiter states:**
  - IDLE: if any `pend`, go to GRANT.
  - GRANT: choose the lowest `pend` port at or after (last granted + 1) mod NPORT. After reset, search starts at port 0. Issue read address 0. Go to SEND.
  - SEND: stream bytes 0..length-1. On acceptance (`tx_valid & tx_ready`) of the byte with `tx_eop`, clear that port's `pend` and go to IDLE.
- Read latency is one cycle, with an output register that supports back-pressure.
- Grant is never preempted. `pend` of the sending port stays 1 until its eop is accepted.

## Timing
- **Reset values:**
  - `tx_data`=0, `tx_valid`=0, `tx_sop`=0, `tx_eop`=0, `tx_port`=0, `pending`=0, `drop`=0;
  - all pointers and flags cleared; state IDLE.
- **Reset mid-frame.** Reset deasserted mid-frame abandons the frame. No partial eop is emitted.
- **Latency.** A strobe sampled at edge k, with the arbiter in IDLE, gives:
  - `pending` high after edge k;
  - GRANT after k+1;
  - `tx_valid` and `tx_sop` high after k+2.
- **Back-pressure.** While `tx_valid` & !`tx_ready`, hold `tx_data`, `tx_sop`, `tx_eop` and `tx_port` stable.
- **Throughput.** Full rate of one byte per cycle when `tx_ready` is held high.
- **Inter-frame gap.** At least two idle cycles (IDLE, then GRANT) between an eop and the next sop.
- **Length-1 frame.** `tx_sop` and `tx_eop` are asserted together.
- **Registered outputs.** `drop` and `pending` are registered. `drop` is high in the cycle after the strobe edge.

## Configuration
- Macro: `REPLY_ARB_PAD_EN`.
- **Defined:** frames shorter than 60 bytes are extended with 0x00 bytes up to 60. `tx_eop` is on byte 59. Frames of 60 bytes or more are unchanged.
- **Undefined:** exactly length bytes are sent, with no padding logic.

## Structure
- **Shared package `ether_pkg`:**
  - bus field indices: `BUS_OK`=10, `BUS_STROBE`=9, `BUS_WRITE`=8;
  - `MIN_FRAME`=60;
  - arbiter state enum (IDLE, GRANT, SEND).
- **Sub-module `reply_buf`:** one instance per port, generated NPORT times. It contains:
  - the 2^AW×8 memory with synchronous read;
  - `wp`, length, `pend`, `ovf` and `lost`;
  - the commit/drop logic.
- **Top level:** holds the round-robin arbiter, the read sequencer, the output register and the optional padding.

## Test plan
- **Single reply.** Port 1 writes 42 bytes 0x00..0x29, then strobe with ok=1. Expect `tx_valid` two cycles after the strobe, `tx_port`=1, bytes 0x00..0x29, sop on 0x00, eop on 0x29, then `pending[1]`=0.
- **Bad CRC.** Port 0 writes 20 bytes, then strobe with ok=0. Expect a `drop[0]` pulse and no `tx_valid`.
- **Round-robin.** Ports 0, 1 and 2 commit on the same edge. Expect frames in order 0, 1, 2. A new port-0 commit arriving during port 2's frame is sent after port 2.
- **Back-pressure.** Toggle `tx_ready` 1,0,0,1 repeatedly. Every byte is delivered exactly once and held stable while stalled.
- **Overflow and write-while-pending.** With AW=7, writing 129 bytes then strobe ok=1 gives a drop. A second packet on a port that is still pending gives a drop, and the first frame is sent intact.
- **Padding (`REPLY_ARB_PAD_EN`).** A 42-byte reply is sent as 60 bytes, with bytes 42..59 = 0x00 and eop on byte 59.
